// File: rtl/uart_tx_engine.sv
// UART transmit engine: frame FSM, shift register, bit-tick and bit counters in one block.
// Latency: txd drops to the start bit on the cycle after accept; a frame occupies
//          OVERSAMPLE*(1+dlen+pen) + stop ticks of baud_tick.
// Backpressure: tx_ready only in IDLE or on the final stop tick; tx_valid is held off otherwise.
//
// Ports:
//   pclk, preset          clock and synchronous active-high reset
//   baud_tick             one-pclk pulse at OVERSAMPLE x baud rate
//   cfg_dlen/pen/eps/sp/stb  character format, snapshotted on accept
//   tx_data/tx_valid/tx_ready  character handshake
//   txd, tx_busy, tx_done serial line, frame-in-progress, end-of-frame pulse
// Optional: define UART_TX_BREAK_EN to add cfg_brk, which forces txd low while set.

module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                            pclk,
  input  logic                            preset,
  input  logic                            baud_tick,
  input  logic [$clog2(DATA_WIDTH+1)-1:0] cfg_dlen,
  input  logic                            cfg_pen,
  input  logic                            cfg_eps,
  input  logic                            cfg_sp,
  input  logic                            cfg_stb,
`ifdef UART_TX_BREAK_EN
  input  logic                            cfg_brk,
`endif
  input  logic [DATA_WIDTH-1:0]           tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic                            txd,
  output logic                            tx_busy,
  output logic                            tx_done
);

  localparam int DLW = $clog2(DATA_WIDTH + 1);
  localparam int TW  = $clog2(2 * OVERSAMPLE);

  // Last tick index of each period length the tick counter has to recognise.
  localparam logic [TW-1:0] OS_LAST     = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'((3 * OVERSAMPLE) / 2 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state_q,     state_d;
  logic [TW-1:0]         tick_q,      tick_d;
  logic [DLW-1:0]        bit_q,       bit_d;
  logic [DATA_WIDTH-1:0] shift_q,     shift_d;
  logic [DLW-1:0]        dlen_q,      dlen_d;
  logic                  pen_q,       pen_d;
  logic                  par_q,       par_d;
  logic [TW-1:0]         stop_last_q, stop_last_d;

  logic [DLW-1:0]        dlen_eff;
  logic [DATA_WIDTH-1:0] data_m;
  logic [TW-1:0]         period_last;
  logic                  period_end;
  logic                  stop_end;
  logic                  accept;
  logic                  txd_fsm;

  // Clamp the requested character length into 5..DATA_WIDTH.
  always_comb begin
    if (cfg_dlen < DLW'(5)) begin
      dlen_eff = DLW'(5);
    end else if (cfg_dlen > DLW'(DATA_WIDTH)) begin
      dlen_eff = DLW'(DATA_WIDTH);
    end else begin
      dlen_eff = cfg_dlen;
    end
  end

  // Zero the bits above the character length so they never reach the parity.
  always_comb begin
    data_m = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(dlen_eff)) begin
        data_m[i] = tx_data[i];
      end
    end
  end

  // Only STOP has a period longer or shorter than one bit time.
  assign period_last = (state_q == S_STOP) ? stop_last_q : OS_LAST;
  assign period_end  = baud_tick && (state_q != S_IDLE) && (tick_q == period_last);
  assign stop_end    = period_end && (state_q == S_STOP);

  assign tx_ready = ~preset & ((state_q == S_IDLE) | stop_end);
  assign tx_done  = ~preset & stop_end;
  assign tx_busy  = (state_q != S_IDLE);
  assign accept   = tx_valid & tx_ready;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    dlen_d      = dlen_q;
    pen_d       = pen_q;
    par_d       = par_q;
    stop_last_d = stop_last_q;
    // Accept wins over the STOP->IDLE step so back-to-back frames have no idle gap.
    if (accept) begin
      state_d = S_START;
      tick_d  = '0;
      bit_d   = '0;
      shift_d = data_m;
      dlen_d  = dlen_eff;
      pen_d   = cfg_pen;
      // Parity is resolved once here so the frame only needs to carry one bit.
      par_d   = cfg_sp ? ~cfg_eps : ((^data_m) ^ ~cfg_eps);
      if (!cfg_stb) begin
        stop_last_d = OS_LAST;
      end else if (dlen_eff == DLW'(5)) begin
        stop_last_d = STOP15_LAST;
      end else begin
        stop_last_d = STOP2_LAST;
      end
    end else if (baud_tick && (state_q != S_IDLE)) begin
      if (tick_q == period_last) begin
        tick_d = '0;
        case (state_q)
          S_START: state_d = S_DATA;
          S_DATA: begin
            shift_d = shift_q >> 1;
            if (bit_q == dlen_q - DLW'(1)) begin
              bit_d   = '0;
              state_d = pen_q ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + DLW'(1);
            end
          end
          S_PARITY: state_d = S_STOP;
          default:  state_d = S_IDLE;
        endcase
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      dlen_q      <= '0;
      pen_q       <= 1'b0;
      par_q       <= 1'b0;
      stop_last_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      dlen_q      <= dlen_d;
      pen_q       <= pen_d;
      par_q       <= par_d;
      stop_last_q <= stop_last_d;
    end
  end

  always_comb begin
    case (state_q)
      S_START:  txd_fsm = 1'b0;
      S_DATA:   txd_fsm = shift_q[0];
      S_PARITY: txd_fsm = par_q;
      default:  txd_fsm = 1'b1;
    endcase
  end

`ifdef UART_TX_BREAK_EN
  assign txd = txd_fsm & ~cfg_brk;
`else
  assign txd = txd_fsm;
`endif

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmit engine. It contains the frame FSM, the shift register, the bit-tick counter and the bit counter in one block. It takes one character per valid/ready handshake and serialises it as start, 5..DATA_WIDTH data bits (LSB first), optional parity (odd/even/stick) and 1, 1.5 or 2 stop bits. It sits between the TX holding register/FIFO and the txd pad, and is paced by an external oversampled baud tick from the baud generator.

Parameters:
DATA_WIDTH, 8, maximum data bits per character; legal range 5..16.
OVERSAMPLE, 16, baud_tick pulses per bit period; must be even and >= 4.

Ports:
pclk  input  1  system clock; all logic on the rising edge.
preset  input  1  synchronous reset, active-high.
baud_tick  input  1  one-pclk pulse at OVERSAMPLE x baud rate.
cfg_dlen  input  $clog2(DATA_WIDTH+1)  data bits per character; values <5 are treated as 5, values >DATA_WIDTH as DATA_WIDTH.
cfg_pen  input  1  parity enable.
cfg_eps  input  1  1 = even parity, 0 = odd parity.
cfg_sp  input  1  stick parity; with cfg_pen, the parity bit is ~cfg_eps.
cfg_stb  input  1  0 = 1 stop bit; 1 = 2 stop bits, or 1.5 stop bits when the effective dlen is 5.
tx_data  input  DATA_WIDTH  character; bits at or above the effective dlen are ignored.
tx_valid  input  1  character available.
tx_ready  output  1  engine can accept a character this cycle.
txd  output  1  serial output; idles high.
tx_busy  output  1  frame in progress (any state other than IDLE).
tx_done  output  1  one-cycle pulse when the last stop period ends.

Behaviour:
- Reset values: txd=1, tx_busy=0, tx_done=0, state=IDLE, all counters=0. tx_ready=0 while preset=1. A reset mid-frame aborts the frame; txd=1 from the next edge.
- Handshake: accept occurs when tx_valid & tx_ready. tx_ready=1 in IDLE, and on the cycle where STOP completes (baud_tick on the final stop tick). tx_ready is combinational from state and counters; it does not depend on tx_valid.
- On accept, latch tx_data, the effective dlen and all cfg_* into a frame snapshot. Config changes mid-frame take effect on the next accept only.
- States and transitions:
  - IDLE: on accept -> START; txd=0 from the following cycle; tick counter=0.
  - START: after OVERSAMPLE ticks -> DATA.
  - DATA: drives shift[0]; shifts right every OVERSAMPLE ticks. After dlen bits -> PARITY if pen, else STOP.
  - PARITY: txd = ^data[dlen-1:0] ^ ~eps when sp=0, or ~eps when sp=1. After OVERSAMPLE ticks -> STOP.
  - STOP: txd=1 for OVERSAMPLE ticks (stb=0), 2*OVERSAMPLE (stb=1, dlen>5) or 3*OVERSAMPLE/2 (stb=1, dlen=5).
- End of STOP:
  - tx_done=1 for that cycle.
  - If accept occurs the same cycle -> START, with no idle gap (back-to-back frame).
  - Otherwise -> IDLE.
- Tick counter advances only on baud_tick. State, bit counter and shift register change only on a baud_tick that completes a period. With no baud_tick, everything holds.
- Frame length in ticks = OVERSAMPLE*(1 + dlen + pen) + stop ticks.
- tx_valid while not ready is held off; the engine never drops or duplicates a character.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input port cfg_brk (1 bit). While cfg_brk=1, txd=0 unconditionally; the FSM, counters and handshake keep running unchanged. txd returns to FSM drive on the first cycle after cfg_brk=0.
- Undefined: port cfg_brk is absent and txd is always the FSM output.

Test Plan:
- 8N1 send, OVERSAMPLE=16, tx_data=0xA5 -> txd bits 0,1,0,1,0,0,1,0,1,1, each 16 ticks; tx_done exactly at tick 160; tx_ready=0 from accept until the final stop tick.
- 7E1 send, tx_data=0x41 -> parity bit 0; then 7O1 -> parity 1; then stick parity with eps=1 -> parity 0. Each frame is 160 ticks.
- dlen=5, stb=1 -> stop phase 24 ticks. dlen=8, stb=1 -> stop phase 32 ticks. cfg_dlen=3 behaves as 5; tx_data bits [7:5] have no effect.
- Back-to-back: tx_valid held high for 3 characters -> no txd-high gap between frames; exactly 3 tx_done pulses and 3 accepts.
- Reset mid-DATA: preset=1 for 1 cycle at tick 50 -> txd=1 on the next edge, tx_busy=0; the next accept starts a clean frame. Also: cfg change mid-frame does not alter the current frame.
- With UART_TX_BREAK_EN: assert cfg_brk mid-frame -> txd=0, tx_done still at tick 160; deassert cfg_brk -> txd follows the FSM on the next cycle.
